// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter with post-reset zero-fill sweep.
// Optional conflict statistics counter enabled by DMEM_ARB_STAT_EN.
module dmem_arbiter #(
    parameter int DATA_W  = 32,
    parameter int DMEMA_W = 8,
    parameter int DEPTH   = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               p0_req,
    input  logic               p0_we,
    input  logic [DMEMA_W-1:0] p0_addr,
    input  logic [DATA_W-1:0]  p0_wdata,
    output logic               p0_gnt,
    output logic               p0_rvalid,
    output logic [DATA_W-1:0]  p0_rdata,
    input  logic               p1_req,
    input  logic               p1_we,
    input  logic [DMEMA_W-1:0] p1_addr,
    input  logic [DATA_W-1:0]  p1_wdata,
    output logic               p1_gnt,
    output logic               p1_rvalid,
    output logic [DATA_W-1:0]  p1_rdata,
    output logic [DMEMA_W-1:0] mem_ra,
    input  logic [DATA_W-1:0]  mem_rd,
    output logic [DMEMA_W-1:0] mem_wa,
    output logic [DATA_W-1:0]  mem_wd,
    output logic               mem_we,
    output logic               o_init_done
`ifdef DMEM_ARB_STAT_EN
    ,
    output logic [15:0]        o_conflict_cnt
`endif
);

    typedef enum logic {INIT, RUN} state_e;

    localparam logic [DMEMA_W-1:0] LAST = DMEMA_W'(DEPTH - 1);

    state_e             state_q;
    logic [DMEMA_W-1:0] cnt_q, cnt_d;
    logic               prio_q, prio_d;
    logic               init_done_q;
    logic               rvalid0_q, rvalid1_q;
    logic [DATA_W-1:0]  rdata0_q, rdata1_q;

    logic run, conflict, g0, g1, rd0, rd1, wr0, wr1;

    assign run      = (state_q == RUN);
    assign conflict = run & p0_req & p1_req & (p0_we == p1_we);

    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (run) begin
            if (conflict) begin
                g0 = ~prio_q;
                g1 = prio_q;
            end else begin
                g0 = p0_req;
                g1 = p1_req;
            end
        end
    end

    assign rd0 = g0 & ~p0_we;
    assign rd1 = g1 & ~p1_we;
    assign wr0 = g0 & p0_we;
    assign wr1 = g1 & p1_we;

    assign p0_gnt      = g0;
    assign p1_gnt      = g1;
    assign p0_rvalid   = rvalid0_q;
    assign p1_rvalid   = rvalid1_q;
    assign p0_rdata    = rdata0_q;
    assign p1_rdata    = rdata1_q;
    assign o_init_done = init_done_q;

    // Write enable is gated by rst_n so nothing is written while reset is held.
    always_comb begin
        mem_ra = '0;
        mem_wa = '0;
        mem_wd = '0;
        mem_we = 1'b0;
        if (rd0) begin
            mem_ra = p0_addr;
        end else if (rd1) begin
            mem_ra = p1_addr;
        end
        if (!run) begin
            mem_we = rst_n;
            mem_wa = cnt_q;
        end else if (wr0) begin
            mem_we = 1'b1;
            mem_wa = p0_addr;
            mem_wd = p0_wdata;
        end else if (wr1) begin
            mem_we = 1'b1;
            mem_wa = p1_addr;
            mem_wd = p1_wdata;
        end
    end

    assign prio_d = conflict ? ~prio_q : prio_q;
    assign cnt_d  = (cnt_q == LAST) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            prio_q      <= 1'b0;
            init_done_q <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            rvalid0_q <= rd0;
            rvalid1_q <= rd1;
            if (rd0) rdata0_q <= mem_rd;
            if (rd1) rdata1_q <= mem_rd;
            prio_q <= prio_d;
            if (!run) begin
                cnt_q <= cnt_d;
                if (cnt_q == LAST) begin
                    state_q     <= RUN;
                    init_done_q <= 1'b1;
                end
            end
        end
    end

`ifdef DMEM_ARB_STAT_EN
    logic [15:0] conf_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conf_cnt_q <= '0;
        end else if (conflict && conf_cnt_q != 16'hFFFF) begin
            conf_cnt_q <= conf_cnt_q + 16'd1;
        end
    end

    assign o_conflict_cnt = conf_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: reference model of grants and memory
// contents, with a separate monitor checking returned read data.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
    logic [7:0]  p0_addr = 0, p1_addr = 0;
    logic [31:0] p0_wdata = 0, p1_wdata = 0;
    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic [7:0]  mem_ra, mem_wa;
    logic [31:0] mem_rd, mem_wd;
    logic        mem_we, o_init_done;
`ifdef DMEM_ARB_STAT_EN
    logic [15:0] o_conflict_cnt;
`endif

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
        .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
        .p1_rdata(p1_rdata),
        .mem_ra(mem_ra), .mem_rd(mem_rd), .mem_wa(mem_wa),
        .mem_wd(mem_wd), .mem_we(mem_we), .o_init_done(o_init_done)
`ifdef DMEM_ARB_STAT_EN
        , .o_conflict_cnt(o_conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Physical memory attached to the DUT ports.
    logic [31:0] dmem [256];
    always @(posedge clk) if (mem_we) dmem[mem_wa] <= mem_wd;
    assign mem_rd = dmem[mem_ra];

    typedef struct {
        int          cyc;
        logic [31:0] d;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        m0, m1;
    logic [31:0] ref_mem [256];
    logic        ref_prio;
    logic [15:0] ref_conf;
    logic        g0, g1;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every rvalid pulse must match the oldest outstanding read.
    always @(negedge clk) begin
        if (rst_n) begin
            if (p0_rvalid) begin
                if (q0.size() == 0) chk("p0_rvalid_spurious", 1, 0);
                else begin
                    m0 = q0.pop_front();
                    chk("p0_rvalid_cycle", cyc, m0.cyc + 1);
                    chk("p0_rdata", p0_rdata, m0.d);
                end
            end else if (q0.size() > 0 && q0[0].cyc < cyc) begin
                chk("p0_rvalid_missing", 0, 1);
                void'(q0.pop_front());
            end
            if (p1_rvalid) begin
                if (q1.size() == 0) chk("p1_rvalid_spurious", 1, 0);
                else begin
                    m1 = q1.pop_front();
                    chk("p1_rvalid_cycle", cyc, m1.cyc + 1);
                    chk("p1_rdata", p1_rdata, m1.d);
                end
            end else if (q1.size() > 0 && q1[0].cyc < cyc) begin
                chk("p1_rvalid_missing", 0, 1);
                void'(q1.pop_front());
            end
        end
    end

    // One RUN cycle: predict grants from the arbitration rules, queue reads,
    // then apply writes to the reference memory (reads see pre-write data).
    task automatic step();
        logic e0, e1, cf;
        @(negedge clk);
        cf = p0_req && p1_req && (p0_we == p1_we);
        if (cf) begin
            e0 = (ref_prio == 1'b0);
            e1 = !e0;
            ref_prio = !ref_prio;
        end else begin
            e0 = p0_req;
            e1 = p1_req;
        end
        chk("p0_gnt", p0_gnt, e0);
        chk("p1_gnt", p1_gnt, e1);
        chk("init_done", o_init_done, 1);
        chk("mem_we", mem_we, (e0 && p0_we) || (e1 && p1_we));
`ifdef DMEM_ARB_STAT_EN
        chk("conflict_cnt", o_conflict_cnt, ref_conf);
        if (cf && ref_conf != 16'hFFFF) ref_conf++;
`endif
        if (e0 && !p0_we) q0.push_back('{cyc, ref_mem[p0_addr]});
        if (e1 && !p1_we) q1.push_back('{cyc, ref_mem[p1_addr]});
        if (e0 && p0_we) ref_mem[p0_addr] = p0_wdata;
        if (e1 && p1_we) ref_mem[p1_addr] = p1_wdata;
        g0 = e0;
        g1 = e1;
        @(posedge clk);
        #1;
    endtask

    task automatic set0(logic r, logic w, logic [7:0] a, logic [31:0] d);
        p0_req = r; p0_we = w; p0_addr = a; p0_wdata = d;
    endtask

    task automatic set1(logic r, logic w, logic [7:0] a, logic [31:0] d);
        p1_req = r; p1_we = w; p1_addr = a; p1_wdata = d;
    endtask

    // Assert reset, check cleared outputs, then check the full zero-fill sweep.
    task automatic do_reset();
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        #1;
        chk("rst_p0_rvalid", p0_rvalid, 0);
        chk("rst_p1_rvalid", p1_rvalid, 0);
        chk("rst_p0_rdata", p0_rdata, 0);
        chk("rst_p1_rdata", p1_rdata, 0);
        chk("rst_init_done", o_init_done, 0);
        chk("rst_gnt", {p0_gnt, p1_gnt}, 0);
        chk("rst_mem_we", mem_we, 0);
        set0(1, 0, 8'h00, 0);
        set1(0, 0, 8'h00, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            chk("init_mem_we", mem_we, 1);
            chk("init_mem_wa", mem_wa, i);
            chk("init_mem_wd", mem_wd, 0);
            chk("init_p0_gnt", p0_gnt, 0);
            chk("init_done_low", o_init_done, 0);
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        ref_prio = 1'b0;
        ref_conf = '0;
        step();
        set0(0, 0, 0, 0);
    endtask

    task automatic rand_run(int n);
        for (int c = 0; c < n; c++) begin
            if (!p0_req && $urandom_range(0, 3) != 0)
                set0(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom);
            if (!p1_req && $urandom_range(0, 3) != 0)
                set1(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom);
            step();
            if (g0) p0_req = 0;
            if (g1) p1_req = 0;
        end
        set0(0, 0, 0, 0);
        set1(0, 0, 0, 0);
    endtask

    initial begin
        #2;
        do_reset();
        // Write then read-after-write from the other requester.
        set0(1, 1, 8'h10, 32'hDEADBEEF);
        step();
        set0(0, 0, 0, 0);
        set1(1, 0, 8'h10, 0);
        step();
        set1(0, 0, 0, 0);
        step();
        // Same-cycle read and write to one address, then repeated read.
        set0(1, 1, 8'h05, 32'h0000_1234);
        set1(1, 0, 8'h05, 0);
        step();
        set0(0, 0, 0, 0);
        step();
        set1(0, 0, 0, 0);
        step();
        // Six back-to-back read conflicts.
        set0(1, 0, 8'h10, 0);
        set1(1, 0, 8'h05, 0);
        for (int i = 0; i < 6; i++) step();
        set0(0, 0, 0, 0);
        set1(0, 0, 0, 0);
        step();
        rand_run(600);
        step();
        // Reset while a p1 read return is in flight.
        set1(1, 0, 8'h10, 0);
        step();
        chk("p1_rvalid_before_rst", p1_rvalid, 1);
        do_reset();
        rand_run(200);
`ifdef DMEM_ARB_STAT_EN
        force dut.conf_cnt_q = 16'hFFFE;
        #1;
        release dut.conf_cnt_q;
        ref_conf = 16'hFFFE;
        set0(1, 1, 8'h20, 32'h1);
        set1(1, 1, 8'h21, 32'h2);
        for (int i = 0; i < 3; i++) step();
        set0(0, 0, 0, 0);
        set1(0, 0, 0, 0);
        step();
        chk("conflict_cnt_sat", o_conflict_cnt, 16'hFFFF);
`endif
        repeat (3) step();
        chk("queues_drained", q0.size() + q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
